// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I R/I/L/S/B field bundles into words, queued with sequential byte addresses.
// Define ENC_BTYPE_EN to enable B-format encoding; otherwise class 4 is rejected as illegal.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_class,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_rs1,
  input  logic [4:0]                   in_rs2,
  input  logic [2:0]                   in_funct3,
  input  logic [6:0]                   in_funct7,
  input  logic [12:0]                  in_imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_addr,
  output logic                         illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic          ill_q, ill_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic [31:0]   addr_q  [DEPTH];
  logic [31:0]   addr_d  [DEPTH];
  logic          legal, accept, push, pop;
  logic [31:0]   word;
  logic          unused_imm;
  assign unused_imm = ^{in_imm[12], in_imm[0]};
  assign word = in_class == 3'd0 ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011}
              : in_class == 3'd1 ? {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011}
              : in_class == 3'd2 ? {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011}
              : in_class == 3'd3 ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011}
`ifdef ENC_BTYPE_EN
              : {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], 7'b1100011};
  assign legal = in_class < 3'd4 || (in_class == 3'd4 && in_funct3[2:1] == 2'b00);
`else
              : 32'h0;
  assign legal = in_class < 3'd4;
`endif
  assign in_ready  = cnt_q < CW'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign pop       = out_valid & out_ready;
  assign out_instr = instr_q[rd_q];
  assign out_addr  = addr_q[rd_q];
  assign illegal   = ill_q;
  assign count     = cnt_q;
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    ill_d   = accept & ~legal & ~flush;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      pc_d  = BASE_ADDR;
    end else begin
      if (push) begin
        instr_d[wr_q] = word;
        addr_d[wr_q]  = pc_q;
        wr_d          = wr_q + AW'(1);
        pc_d          = pc_q + 32'd4;
      end
      if (pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      pc_q    <= BASE_ADDR;
      ill_q   <= 1'b0;
      instr_q <= '{default: '0};
      addr_q  <= '{default: '0};
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ill_q   <= ill_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scoreboard bench for instr_encoder (honours ENC_BTYPE_EN).
module tb_instr_encoder;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0]  in_class = '0, in_funct3 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [12:0] in_imm = '0;
  logic        in_ready, out_valid, illegal;
  logic [31:0] out_instr, out_addr;
  logic [2:0]  count;
  int          errors = 0, checks = 0;
  logic [63:0] exp_q [$];
  logic [31:0] pc_m = '0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .illegal(illegal), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference packing built bit-field by bit-field from the ISA layout.
  function automatic logic [31:0] enc(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [12:0] imm);
    logic [31:0] w;
    w = '0;
    w[14:12] = f3;
    w[19:15] = rs1;
    case (c)
      3'd0: begin w[6:0] = 7'h33; w[11:7] = rd; w[24:20] = rs2; w[31:25] = f7; end
      3'd1: begin w[6:0] = 7'h13; w[11:7] = rd; w[31:20] = imm[11:0]; end
      3'd2: begin w[6:0] = 7'h03; w[11:7] = rd; w[31:20] = imm[11:0]; end
      3'd3: begin w[6:0] = 7'h23; w[11:7] = imm[4:0]; w[24:20] = rs2; w[31:25] = imm[11:5]; end
      default: begin
        w[6:0] = 7'h63; w[7] = imm[11]; w[11:8] = imm[4:1];
        w[24:20] = rs2; w[30:25] = imm[10:5]; w[31] = imm[12];
      end
    endcase
    return w;
  endfunction

  function automatic bit legal_m(input logic [2:0] c, input logic [2:0] f3);
`ifdef ENC_BTYPE_EN
    return c <= 3'd3 || (c == 3'd4 && (f3 == 3'b000 || f3 == 3'b001));
`else
    return c <= 3'd3;
`endif
  endfunction

  task automatic drive(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [12:0] imm);
    in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask

  task automatic send(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [12:0] imm);
    @(negedge clk);
    drive(c, rd, rs1, rs2, f3, f7, imm);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (legal_m(c, f3)) begin
      exp_q.push_back({enc(c, rd, rs1, rs2, f3, f7, imm), pc_m});
      pc_m += 32'd4;
      chk("no_illegal", {31'b0, illegal}, 32'd0);
    end else chk("illegal_pulse", {31'b0, illegal}, 32'd1);
  endtask

  task automatic check_head();
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: queue size 0, required >0");
      return;
    end
    e = exp_q.pop_front();
    chk("out_instr", out_instr, e[63:32]);
    chk("out_addr", out_addr, e[31:0]);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      @(negedge clk);
      out_ready = 1'b1;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("out_valid", {31'b0, out_valid}, 32'd1);
      check_head();
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    pc_m = 32'h0;
    exp_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
    chk("r_latency", {31'b0, out_valid}, 32'd1);
    chk("r_word", out_instr, 32'h002081B3);
    chk("r_addr", out_addr, 32'h0);
    drain(1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("empty_pop_count", 32'(count), 32'd0);

    do_flush();
    send(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0FFF);
    chk("addi_word", out_instr, 32'hFFF00293);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 13'd8);
    chk("is_count", 32'(count), 32'd2);
    drain(1);
    @(negedge clk);
    chk("sw_word", out_instr, 32'h0020A423);
    chk("sw_addr", out_addr, 32'h4);
    drain(1);

    do_flush();
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 13'd8);
`ifdef ENC_BTYPE_EN
    chk("beq_word", out_instr, 32'h00208463);
`else
    chk("btype_off_count", 32'(count), 32'd0);
`endif
    drain(exp_q.size());

    do_flush();
    send(3'd5, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 13'd8);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
    chk("post_illegal_addr", out_addr, 32'h0);
    chk("post_illegal_count", 32'(count), 32'd1);
    drain(1);

    do_flush();
    for (int i = 0; i < 4; i++)
      send(3'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 7'($urandom), 13'($urandom));
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("full_count", 32'(count), 32'd4);
    @(negedge clk);
    drive(3'd0, 5'd7, 5'd6, 5'd5, 3'd0, 7'h20, 13'd0);
    exp_q.push_back({enc(3'd0, 5'd7, 5'd6, 5'd5, 3'd0, 7'h20, 13'd0), pc_m});
    pc_m += 32'd4;
    @(posedge clk);
    #1;
    chk("full_no_push", 32'(count), 32'd4);
    @(negedge clk);
    check_head();
    chk("full_pop_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("full_pop_count", 32'(count), 32'd3);
    @(negedge clk);
    check_head();
    chk("ready_after_pop", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("push_pop_count", 32'(count), 32'd3);
    drain(3);
    chk("fifth_pc", pc_m, 32'h14);

    for (int i = 0; i < 3; i++) send(3'd2, 5'(i), 5'd4, 5'd0, 3'b010, 7'd0, 13'(4 * i));
    chk("three_queued", 32'(count), 32'd3);
    @(negedge clk);
    flush = 1'b1;
    drive(3'd0, 5'd9, 5'd8, 5'd7, 3'd0, 7'd0, 13'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    pc_m = 32'h0;
    exp_q.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
    chk("flush_base_addr", out_addr, 32'h0);
    drain(1);

    send(3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 13'd1);
    send(3'd1, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 13'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    pc_m = 32'h0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0FFF);
    chk("rst_base_addr", out_addr, 32'h0);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder and program buffer. It accepts field bundles (class, register indices, funct fields, immediate) over a valid/ready handshake, packs them into 32-bit R/I/L/S/B-format words using the same opcode map as the pipeline's instruction decoder, and queues them in a small FIFO. Each queued word is tagged with a sequential byte address. It sits between the test/boot program source and instruction memory, and is the write-side counterpart of the decode stage.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- BASE_ADDR, 32'h0000_0000: address tagged on the first word after reset or flush
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of FIFO and address counter
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept; equals (count < DEPTH)
- in_class  input  3  0=R, 1=I, 2=L, 3=S, 4=B; 5–7 illegal
- in_rd, in_rs1, in_rs2  input  5 each  register indices
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R only)
- in_imm  input  13  immediate; [11:0] for I/L/S, [12:1] for B (bit 0 ignored)
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head
- out_instr  output  32  encoded word at head
- out_addr  output  32  byte address of head word
- illegal  output  1  one-cycle pulse: rejected bundle
- count  output  $clog2(DEPTH+1)  occupancy

## Operation
- Accept = in_valid & in_ready; pop = out_valid & out_ready.
- Encoding (opcode in [6:0]):
  - R: funct7|rs2|rs1|funct3|rd|0110011
  - I: imm[11:0]|rs1|funct3|rd|0010011
  - L: imm[11:0]|rs1|funct3|rd|0000011
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011
- Fields not used by a format are ignored.
- Illegal when in_class > 4, or when class B has funct3 ∉ {000, 001}.
  - Illegal bundles are still accepted (handshake completes) but are not enqueued.
  - pc does not advance; illegal pulses the cycle after the accept.
- Legal accept: write {word, pc} at the tail; pc ← pc + 4, wrapping mod 2^32.
- FIFO: circular, wr/rd pointers wrap at DEPTH; head drives out_instr/out_addr.
- flush: count ← 0, pointers ← 0, pc ← BASE_ADDR, illegal ← 0.
  - Any same-cycle accept or pop is discarded; in_ready still reflects pre-flush count.
- Reset values:
  - count = 0, pointers = 0, pc = BASE_ADDR
  - storage = 0, so out_instr = 0 and out_addr = 0
  - out_valid = 0, illegal = 0, in_ready = 1

## Timing
- Latency: a word accepted at edge N is presented with out_valid = 1 after edge N (next cycle).
- in_ready depends on the registered count only; there is no combinational path from out_ready.
  - When full, a same-cycle pop does not allow a push.
- Simultaneous legal push and pop when not full or empty: count unchanged, both pointers advance.
- Empty: out_valid = 0; out_ready is ignored.
- out_instr/out_addr hold stable while out_valid & !out_ready.
- Reset asserted mid-stream: FIFO contents are lost immediately (async); no partial words.

## Configuration
- ENC_BTYPE_EN defined: class 4 encodes as the B format above.
- ENC_BTYPE_EN undefined: class 4 is treated as illegal (illegal pulse, not enqueued); the B packing logic is absent.

## Test plan
- R add x3,x1,x2 (class 0, rd 3, rs1 1, rs2 2, f3 0, f7 0) -> out_instr 0x002081B3, out_addr 0x0 one cycle after accept.
- I addi x5,x0,-1 (imm 0xFFF) then S sw x2,8(x1) (f3 010, imm 8) -> 0xFFF00293 @0x0, then 0x0020A423 @0x4.
- B beq x1,x2,+8 (f3 000, imm 8) -> 0x00208463; with ENC_BTYPE_EN undefined -> illegal pulse, count stays 0.
- Class 5, then B with f3 010, then a legal R -> two illegal pulses; the R word gets out_addr 0x0.
- out_ready = 0, present 5 legal bundles -> in_ready drops after 4, count = 4; raise out_ready -> addresses 0x0, 0x4, 0x8, 0xC, then the 5th at 0x10.
- flush with 3 queued, and rst_n low mid-stream -> count 0, out_valid 0, next word tagged BASE_ADDR.
